// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: loadable 128-word program store, PC, and a
// valid/ready issue port toward the single-issue 16-bit execute stage.
module instr_fetch_decode #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              abort,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        op,
    output logic              rd,
    output logic              rs,
    output logic              mem_mode,
    output logic [6:0]        operand,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] pc;

    logic [3:0] fetch_op;
    logic       fetch_rd;
    logic       fetch_rs;
    logic       fetch_mode;
    logic [6:0] fetch_operand;
    logic       fetch_legal;
    logic       fetch_jmp;
    logic       fetch_halt;
    logic       handshake;
    logic       stopping;

    assign fetch_op      = mem[pc][15:12];
    assign fetch_rd      = mem[pc][11];
    assign fetch_rs      = mem[pc][10];
    assign fetch_mode    = mem[pc][9];
    assign fetch_operand = mem[pc][6:0];

    assign fetch_legal = (fetch_op <= 4'd6);
    assign fetch_jmp   = (fetch_op == 4'd7);
    assign fetch_halt  = (fetch_op == 4'hF);
    assign handshake   = instr_valid & instr_ready;
    assign stopping    = abort && (state != IDLE);

    // Program store only accepts writes while nothing is being fetched.
    always_ff @(posedge clk) begin
        if (prog_we && (state == IDLE || state == HALTED))
            mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (stopping) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, HALTED: if (start) state_next = FETCH;
                FETCH: begin
                    if (fetch_legal)
                        state_next = ISSUE;
                    else if (fetch_jmp)
                        state_next = FETCH;
                    else
                        state_next = HALTED;
                end
                ISSUE: if (handshake) state_next = FETCH;
                default: state_next = IDLE;
            endcase
        end
    end

    // Abort wins over a same-cycle handshake: the instruction is dropped
    // and PC stays on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instr_valid <= 1'b0;
            op          <= '0;
            rd          <= 1'b0;
            rs          <= 1'b0;
            mem_mode    <= 1'b0;
            operand     <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
        end else if (stopping) begin
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc      <= start_pc;
                        halted  <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
                FETCH: begin
                    if (fetch_legal) begin
                        op          <= fetch_op;
                        rd          <= fetch_rd;
                        rs          <= fetch_rs;
                        mem_mode    <= fetch_mode;
                        operand     <= fetch_operand;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                    end else if (fetch_jmp) begin
                        pc <= ADDR_W'(fetch_operand);
                    end else begin
                        halted  <= 1'b1;
                        illegal <= ~fetch_halt;
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state == FETCH) || (state == ISSUE);
    end

endmodule
